// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: I2C target (slave) backed by a byte-addressed register
// file with an auto-incrementing pointer.
// Optional feature macro: I2C_TGT_STRETCH_EN holds SCL low for STRETCH_CYCLES
// clk_i cycles after every ACK/NACK bit. Without it scl_o is tied high.
`timescale 1ns/1ps
module i2c_target_regfile #(
  parameter logic [6:0]  TGT_ADDR       = 7'h22,
  parameter int unsigned MEM_DEPTH      = 16,
  parameter int unsigned STRETCH_CYCLES = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         scl_i,
  input  logic                         sda_i,
  output logic                         scl_o,
  output logic                         sda_o,
  output logic                         busy_o,
  output logic                         wr_strobe_o,
  output logic [$clog2(MEM_DEPTH)-1:0] wr_addr_o,
  output logic [7:0]                   wr_data_o,
  output logic                         rd_strobe_o
);
  localparam int unsigned AW = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_PTR, ST_WR_DATA, ST_RD_LOAD, ST_RD_DATA, ST_RD_ACK, ST_WAIT
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            ack_phase_q, ack_phase_d;
  logic            rw_q, rw_d;
  logic            mack_q, mack_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            sda_q, sda_d;
  logic            busy_q, busy_d;
  logic            wr_strobe_q, wr_strobe_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic            rd_strobe_q, rd_strobe_d;
  logic [7:0]      mem_q [MEM_DEPTH];

  logic scl_meta_q, scl_sync_q, scl_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;
  logic scl_rise, scl_fall, start_cond, stop_cond;
  logic stretching, stretch_start;
  logic [7:0] byte_in;

  // Two-flop synchronizers plus one edge-history flop; idle bus reads as high.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      scl_meta_q <= 1'b1; scl_sync_q <= 1'b1; scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1; sda_sync_q <= 1'b1; sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_i; scl_sync_q <= scl_meta_q; scl_prev_q <= scl_sync_q;
      sda_meta_q <= sda_i; sda_sync_q <= sda_meta_q; sda_prev_q <= sda_sync_q;
    end
  end

  // SCL edges are ignored while this target is itself holding SCL low.
  assign scl_rise   = scl_sync_q & ~scl_prev_q & ~stretching;
  assign scl_fall   = ~scl_sync_q & scl_prev_q & ~stretching;
  assign start_cond = ~sda_sync_q & sda_prev_q & scl_sync_q & scl_prev_q;
  assign stop_cond  = sda_sync_q & ~sda_prev_q & scl_sync_q & scl_prev_q;
  assign byte_in    = {shift_q[6:0], sda_sync_q};

  // Protocol FSM: bus conditions first, then per-state bit handling.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    ack_phase_d   = ack_phase_q;
    rw_d          = rw_q;
    mack_d        = mack_q;
    ptr_d         = ptr_q;
    sda_d         = sda_q;
    busy_d        = busy_q;
    wr_strobe_d   = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    rd_strobe_d   = 1'b0;
    stretch_start = 1'b0;
    if (stop_cond) begin
      state_d     = ST_IDLE;
      busy_d      = 1'b0;
      sda_d       = 1'b1;
      bit_cnt_d   = '0;
      ack_phase_d = 1'b0;
    end else if (start_cond) begin
      state_d     = ST_ADDR;
      sda_d       = 1'b1;
      bit_cnt_d   = '0;
      ack_phase_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR, ST_PTR, ST_WR_DATA: begin
          // bit_cnt==8 means the byte is complete and the ACK slot is pending;
          // ack_phase marks SDA held low until the 9th-bit SCL fall.
          if (ack_phase_q) begin
            if (scl_fall) begin
              sda_d         = 1'b1;
              ack_phase_d   = 1'b0;
              bit_cnt_d     = '0;
              stretch_start = 1'b1;
              if (state_q == ST_ADDR) state_d = rw_q ? ST_RD_LOAD : ST_PTR;
              else                    state_d = ST_WR_DATA;
            end
          end else if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (state_q == ST_ADDR) begin
                if (byte_in[7:1] == TGT_ADDR) begin
                  busy_d = 1'b1;
                  rw_d   = byte_in[0];
                end else begin
                  state_d   = ST_IDLE;
                  busy_d    = 1'b0;
                  bit_cnt_d = '0;
                end
              end else if (state_q == ST_PTR) begin
                ptr_d = byte_in[AW-1:0];
              end else begin
                wr_strobe_d = 1'b1;
                wr_addr_d   = ptr_q;
                wr_data_d   = byte_in;
                ptr_d       = ptr_q + AW'(1);
              end
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_d       = 1'b0;
            ack_phase_d = 1'b1;
          end
        end
        ST_RD_LOAD: begin
          shift_d     = mem_q[ptr_q];
          sda_d       = mem_q[ptr_q][7];
          rd_strobe_d = 1'b1;
          ptr_d       = ptr_q + AW'(1);
          bit_cnt_d   = '0;
          state_d     = ST_RD_DATA;
        end
        ST_RD_DATA: begin
          // bit_cnt counts bits already sampled by the controller.
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_d     = 1'b1;
              bit_cnt_d = '0;
              state_d   = ST_RD_ACK;
            end else if (bit_cnt_q != 4'd0) begin
              shift_d = {shift_q[6:0], shift_q[7]};
              sda_d   = shift_q[6];
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            mack_d    = sda_sync_q;
            bit_cnt_d = 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            bit_cnt_d     = '0;
            stretch_start = 1'b1;
            state_d       = mack_q ? ST_WAIT : ST_RD_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

  // Control/state registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ack_phase_q <= 1'b0;
      rw_q        <= 1'b0;
      mack_q      <= 1'b1;
      ptr_q       <= '0;
      sda_q       <= 1'b1;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_strobe_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ack_phase_q <= ack_phase_d;
      rw_q        <= rw_d;
      mack_q      <= mack_d;
      ptr_q       <= ptr_d;
      sda_q       <= sda_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_strobe_q <= rd_strobe_d;
    end
  end

  // Register file: cleared on reset, written on each committed byte.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_strobe_d) begin
      mem_q[wr_addr_d] <= wr_data_d;
    end
  end

`ifdef I2C_TGT_STRETCH_EN
  localparam int unsigned SW = $clog2(STRETCH_CYCLES + 1);
  logic [SW-1:0] stretch_q, stretch_d;
  logic          scl_q, scl_d;

  assign stretching = (stretch_q != '0);

  // Stretch counter: loaded at the ACK/NACK fall, SCL low while nonzero.
  always_comb begin
    stretch_d = stretch_q;
    if (stretch_start)   stretch_d = SW'(STRETCH_CYCLES);
    else if (stretching) stretch_d = stretch_q - SW'(1);
    scl_d = (stretch_d == '0);
  end

  // Stretch counter and registered SCL drive.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stretch_q <= '0;
      scl_q     <= 1'b1;
    end else begin
      stretch_q <= stretch_d;
      scl_q     <= scl_d;
    end
  end

  assign scl_o = scl_q;
`else
  logic stretch_unused;
  assign stretch_unused = stretch_start & (STRETCH_CYCLES != 0);
  assign stretching     = 1'b0;
  assign scl_o          = 1'b1;
`endif

  assign sda_o       = sda_q;
  assign busy_o      = busy_q;
  assign wr_strobe_o = wr_strobe_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign rd_strobe_o = rd_strobe_q;

endmodule
